// File: rtl/mul32_seq.sv
// mul32_seq: sequential 32x32 -> 64 unsigned multiplier built on one shared
// 16x16 multiplier. Each operation walks four partial-product states.
// Optional build macro: MUL32_SEQ_ZERO_SKIP_EN (a zero operand skips straight
// to DONE with a zero product).

// Purely combinational 16x16 -> 32 unsigned multiplier.
module mul_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [31:0] o_p_c
);
    assign o_p_c = 32'(i_a) * 32'(i_b);
endmodule

module mul32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    localparam int unsigned OP_W   = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned PROD_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S0   = 3'd1,
        ST_S1   = 3'd2,
        ST_S2   = 3'd3,
        ST_S3   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [PROD_W-1:0]   r_acc;
    logic [PROD_W-1:0]   r_product;
    logic                w_accept;
    logic                w_step;
    logic [HALF_W-1:0]   w_mul_a;
    logic [HALF_W-1:0]   w_mul_b;
    logic [2*HALF_W-1:0] w_pp;
    logic [PROD_W-1:0]   w_pp_shifted;
    logic [PROD_W-1:0]   w_sum;
`ifdef MUL32_SEQ_ZERO_SKIP_EN
    logic                w_zero;
    assign w_zero = (op_a == '0) || (op_b == '0);
`endif

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_step   = (r_state == ST_S0) || (r_state == ST_S1) ||
                      (r_state == ST_S2) || (r_state == ST_S3);

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == ST_IDLE);
            r_busy  <= (w_next == ST_S0) || (w_next == ST_S1) ||
                       (w_next == ST_S2) || (w_next == ST_S3);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Next-state logic: fixed walk through the four partial products.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
`ifdef MUL32_SEQ_ZERO_SKIP_EN
                    w_next = w_zero ? ST_DONE : ST_S0;
`else
                    w_next = ST_S0;
`endif
                end
            end
            ST_S0:   w_next = ST_S1;
            ST_S1:   w_next = ST_S2;
            ST_S2:   w_next = ST_S3;
            ST_S3:   w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand half selection and partial-product alignment for the current state.
    always_comb begin
        w_mul_a      = r_a[HALF_W-1:0];
        w_mul_b      = r_b[HALF_W-1:0];
        w_pp_shifted = '0;
        unique case (r_state)
            ST_S0: w_pp_shifted = PROD_W'(w_pp);
            ST_S1: begin
                w_mul_a      = r_a[OP_W-1:HALF_W];
                w_pp_shifted = PROD_W'(w_pp) << HALF_W;
            end
            ST_S2: begin
                w_mul_b      = r_b[OP_W-1:HALF_W];
                w_pp_shifted = PROD_W'(w_pp) << HALF_W;
            end
            ST_S3: begin
                w_mul_a      = r_a[OP_W-1:HALF_W];
                w_mul_b      = r_b[OP_W-1:HALF_W];
                w_pp_shifted = PROD_W'(w_pp) << OP_W;
            end
            default: w_pp_shifted = '0;
        endcase
    end

    assign w_sum = r_acc + w_pp_shifted;

    mul_16bit u_mul (
        .i_a   (w_mul_a),
        .i_b   (w_mul_b),
        .o_p_c (w_pp)
    );

    // Operand capture, accumulation and result load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a   <= op_a;
            r_b   <= op_b;
            r_acc <= '0;
`ifdef MUL32_SEQ_ZERO_SKIP_EN
            if (w_zero) begin
                r_product <= '0;
            end
`endif
        end else if (w_step) begin
            r_acc <= w_sum;
            if (r_state == ST_S3) begin
                r_product <= w_sum;
            end
        end
    end

    assign ready   = r_ready;
    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_mul32_seq.sv
// Directed + random bench for mul32_seq. Honors MUL32_SEQ_ZERO_SKIP_EN for
// the expected zero-operand latency.
`timescale 1ns/1ps
module tb_mul32_seq;

`ifdef MUL32_SEQ_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_vec = 0;
    int n_err = 0;

    mul32_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [63:0] flags();
        return 64'({ready, busy, done});
    endfunction

    // Follows one accepted operation to completion and one cycle beyond.
    task automatic track(input int lat, input logic [63:0] prev, input logic [63:0] exp_p);
        @(posedge clk);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                op_a  = $urandom;
                op_b  = $urandom;
            end
            if (c < lat) begin
                chk("busy_flags", flags(), 64'b010);
                chk("prod_hold", product, prev);
            end else if (c == lat) begin
                chk("done_flags", flags(), 64'b001);
                chk("product", product, exp_p);
            end else begin
                chk("idle_flags", flags(), 64'b100);
                chk("prod_after", product, exp_p);
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [63:0] prev, input logic [63:0] exp_p);
        @(negedge clk);
        chk("ready_pre", flags(), 64'b100);
        issue(a, b);
        track(lat, prev, exp_p);
    endtask

    localparam logic [31:0] CA = 32'h0001_0003;
    localparam logic [31:0] CB = 32'h0002_0005;
    localparam logic [63:0] CP = 64'h0000_0002_000B_000F;

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] last_p;
        int          lat;

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_flags", flags(), 64'b100);
        chk("rst_product", product, 64'h0);

        // Release reset mid-cycle; start taken on the very next rising edge
        #2 rst_n = 1'b1;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        track(5, 64'h0, 64'hFFFF_FFFE_0000_0001);

        // Result held while the next operation runs
        run_op(32'h0000_FFFF, 32'h0001_0001, 5, 64'hFFFF_FFFE_0000_0001, 64'h0000_0000_FFFF_FFFF);
        run_op(32'h0001_0000, 32'h0001_0000, 5, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000);

        // start held high: accept every 6 cycles, operands scrambled while busy
        @(negedge clk);
        issue(CA, CB);
        @(posedge clk);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c % 6 == 5) begin
                chk("cont_done", flags(), 64'b001);
                chk("cont_product", product, CP);
            end else if (c % 6 == 0) begin
                chk("cont_idle", flags(), 64'b100);
            end else begin
                chk("cont_busy", flags(), 64'b010);
            end
            if (c % 6 == 0) begin
                op_a  = CA;
                op_b  = CB;
                start = (c != 18);
            end else begin
                op_a = $urandom;
                op_b = $urandom;
            end
        end

        // Zero operand
        run_op(32'h0, 32'h1234_5678, ZSKIP ? 1 : 5, CP, 64'h0);

        // Reset during S2 aborts, next start completes
        @(negedge clk);
        issue(32'h0000_FFFF, 32'h0001_0001);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_flags", flags(), 64'b100);
        chk("abort_product", product, 64'h0);
        #1 rst_n = 1'b1;
        issue(32'hFFFF_FFFF, 32'h0000_0002);
        track(5, 64'h0, 64'h0000_0001_FFFF_FFFE);

        // Random operand pairs against a 64-bit reference
        last_p = 64'h0000_0001_FFFF_FFFE;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 50 == 7) ra = 32'h0;
            if (i % 77 == 3) rb = 32'h0;
            lat = (ZSKIP && (ra == 0 || rb == 0)) ? 1 : 5;
            run_op(ra, rb, lat, last_p, 64'(ra) * 64'(rb));
            last_p = 64'(ra) * 64'(rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
